decode_pipe_stage: RTL

Pipelined decode stage for the Y86-64 processor. It sits between fetch and execute and holds the F/D pipeline register (D_*) with stall/bubble control. It also holds the 15-entry register file with its write-back port. Combinationally it produces srcA/srcB/dstE/dstM and the forwarded valA/valB that feed the E register.

---
 rtl/decode_pipe_stage.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/decode_pipe_stage.sv
// -----------------------------------------------------------------------------
// decode_pipe_stage
//
// Y86-64 pipelined decode stage. It holds the F/D pipeline register (D_*) with
// stall/bubble control, the 15-entry register file (r0..r14) with its E and M
// write-back ports, and the combinational source/destination ID decode and
// operand selection that feed the E register.
//
// Optional feature macro: DECODE_FWD_EN
//   defined   : valA/valB are bypassed from the e/M/W stages
//               (e_dstE, M_dstM, M_dstE, W_dstM, W_dstE, then the register file).
//   undefined : valA/valB come straight from the register file (the valP select
//               for call/jXX is kept); hazards are resolved by external stalls.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   D_stall, D_bubble          D register hold / load-nop controls
//   f_icode..f_valP            fetched instruction fields
//   e_dstE, e_valE             execute-stage result (post-cond)
//   M_dstE, M_valE             memory-stage ALU result
//   M_dstM, m_valM             memory-stage load data
//   W_dstE, W_valE             write-back port E
//   W_dstM, W_valM             write-back port M (wins on same register)
//   d_icode, d_ifun, d_valC    D register fields passed to E
//   d_valA, d_valB             selected / forwarded operands
//   d_srcA, d_srcB             source register IDs
//   d_dstE, d_dstM             destination register IDs
// -----------------------------------------------------------------------------
module decode_pipe_stage #(
    parameter logic [3:0] RSP   = 4'd4,
    parameter logic [3:0] RNONE = 4'd15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        D_stall,
    input  logic        D_bubble,
    input  logic [3:0]  f_icode,
    input  logic [3:0]  f_ifun,
    input  logic [3:0]  f_rA,
    input  logic [3:0]  f_rB,
    input  logic [63:0] f_valC,
    input  logic [63:0] f_valP,
    input  logic [3:0]  e_dstE,
    input  logic [63:0] e_valE,
    input  logic [3:0]  M_dstE,
    input  logic [63:0] M_valE,
    input  logic [3:0]  M_dstM,
    input  logic [63:0] m_valM,
    input  logic [3:0]  W_dstE,
    input  logic [63:0] W_valE,
    input  logic [3:0]  W_dstM,
    input  logic [63:0] W_valM,
    output logic [3:0]  d_icode,
    output logic [3:0]  d_ifun,
    output logic [63:0] d_valC,
    output logic [63:0] d_valA,
    output logic [63:0] d_valB,
    output logic [3:0]  d_srcA,
    output logic [3:0]  d_srcB,
    output logic [3:0]  d_dstE,
    output logic [3:0]  d_dstM
);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // F/D pipeline register
    logic [3:0]  D_icode;
    logic [3:0]  D_ifun;
    logic [3:0]  D_rA;
    logic [3:0]  D_rB;
    logic [63:0] D_valC;
    logic [63:0] D_valP;

    // register file, r0..r14 (ID 15 is "no register" and has no storage)
    logic [63:0] rf [0:14];

    logic [3:0]  src_a;
    logic [3:0]  src_b;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [63:0] rf_a;
    logic [63:0] rf_b;
    logic [63:0] sel_a;
    logic [63:0] sel_b;

    always_ff @(posedge clk) begin
        if (rst || (!D_stall && D_bubble)) begin
            D_icode <= I_NOP;
            D_ifun  <= 4'h0;
            D_rA    <= RNONE;
            D_rB    <= RNONE;
            D_valC  <= 64'd0;
            D_valP  <= 64'd0;
        end else if (!D_stall) begin
            D_icode <= f_icode;
            D_ifun  <= f_ifun;
            D_rA    <= f_rA;
            D_rB    <= f_rB;
            D_valC  <= f_valC;
            D_valP  <= f_valP;
        end
    end

    // Port M is written after port E so it wins when both target one register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) begin
                rf[i] <= 64'd0;
            end
        end else begin
            if (W_dstE != RNONE) begin
                rf[W_dstE] <= W_valE;
            end
            if (W_dstM != RNONE) begin
                rf[W_dstM] <= W_valM;
            end
        end
    end

    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (D_icode)
            I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: src_a = D_rA;
            I_RET, I_POPQ:                      src_a = RSP;
            default:                            src_a = RNONE;
        endcase
        case (D_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ:            src_b = D_rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:       src_b = RSP;
            default:                              src_b = RNONE;
        endcase
        case (D_icode)
            I_RRMOVQ, I_IRMOVQ, I_OPQ:            dst_e = D_rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:       dst_e = RSP;
            default:                              dst_e = RNONE;
        endcase
        case (D_icode)
            I_MRMOVQ, I_POPQ:                     dst_m = D_rA;
            default:                              dst_m = RNONE;
        endcase
    end

    assign rf_a = (src_a == RNONE) ? 64'd0 : rf[src_a];
    assign rf_b = (src_b == RNONE) ? 64'd0 : rf[src_b];

`ifdef DECODE_FWD_EN
    // Youngest producer first; a RNONE source never matches anything.
    function automatic logic [63:0] fwd(input logic [3:0] src, input logic [63:0] rf_val);
        logic [63:0] v;
        v = rf_val;
        if (src == RNONE)        v = 64'd0;
        else if (src == e_dstE)  v = e_valE;
        else if (src == M_dstM)  v = m_valM;
        else if (src == M_dstE)  v = M_valE;
        else if (src == W_dstM)  v = W_valM;
        else if (src == W_dstE)  v = W_valE;
        return v;
    endfunction

    assign sel_a = fwd(src_a, rf_a);
    assign sel_b = fwd(src_b, rf_b);
`else
    // Bypass sources are unused here; fold them so they are visibly consumed.
    logic unused_fwd;
    assign unused_fwd = ^{e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM};

    assign sel_a = rf_a;
    assign sel_b = rf_b;
`endif

    // call and jXX carry valP down the A path instead of a register.
    assign d_valA  = (D_icode == I_JXX || D_icode == I_CALL) ? D_valP : sel_a;
    assign d_valB  = sel_b;
    assign d_icode = D_icode;
    assign d_ifun  = D_ifun;
    assign d_valC  = D_valC;
    assign d_srcA  = src_a;
    assign d_srcB  = src_b;
    assign d_dstE  = dst_e;
    assign d_dstM  = dst_m;

endmodule
